// File: rtl/pbit_group_scheduler.sv
// Steps the p-bit colour-group index through fixed settle windows, counts full sweeps and
// ends a run on a sweep target or a graceful stop request.
module pbit_group_scheduler #(
  parameter int unsigned NUM_GROUPS    = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned SWEEP_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [2:0]         group_EN,
  output logic               update_en,
  output logic               busy,
  output logic               sweep_done,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_count
);

  localparam int unsigned    SlotW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SlotW-1:0] SlotLast  = SlotW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       GroupLast = 3'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [SlotW-1:0]   slot_q, slot_d;
  logic [2:0]         group_q, group_d;
  logic [SWEEP_W-1:0] target_q, target_d;
  logic [SWEEP_W-1:0] count_q, count_d;
  logic [SWEEP_W-1:0] count_inc;
  logic               stop_q, stop_d;
  logic               update_en_q, update_en_d;
  logic               busy_q, busy_d;
  logic               sweep_done_q, sweep_done_d;
  logic               done_q, done_d;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    group_d   = group_q;
    target_d  = target_q;
    count_d   = count_q;
    stop_d    = stop_q;
    count_inc = (&count_q) ? count_q : count_q + SWEEP_W'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          target_d = num_sweeps;
          count_d  = '0;
          stop_d   = 1'b0;
          slot_d   = '0;
          group_d  = '0;
        end
      end
      StRun: begin
        if (stop) stop_d = 1'b1;
        if (slot_q == SlotLast) begin
          slot_d = '0;
          if (group_q == GroupLast) begin
            group_d = '0;
            count_d = count_inc;
            // A stop arriving in the closing cycle still ends the run at this boundary.
            if ((target_q != '0 && count_inc == target_q) || stop_q || stop) begin
              state_d = StDone;
              stop_d  = 1'b0;
            end
          end else begin
            group_d = group_q + 3'd1;
          end
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from next state so that every output leaves a flop.
    busy_d       = (state_d == StRun);
    update_en_d  = busy_d && (slot_d == '0);
    sweep_done_d = busy_d && (slot_d == SlotLast) && (group_d == GroupLast);
    done_d       = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      group_q      <= '0;
      target_q     <= '0;
      count_q      <= '0;
      stop_q       <= 1'b0;
      update_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      group_q      <= group_d;
      target_q     <= target_d;
      count_q      <= count_d;
      stop_q       <= stop_d;
      update_en_q  <= update_en_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      done_q       <= done_d;
    end
  end

  assign group_EN    = group_q;
  assign update_en   = update_en_q;
  assign busy        = busy_q;
  assign sweep_done  = sweep_done_q;
  assign done        = done_q;
  assign sweep_count = count_q;

endmodule

// File: tb/tb_pbit_group_scheduler.sv
// Drives three scheduler configurations and checks every cycle of each run against a
// cycle-index model of the sweep/slot schedule.
module tb_pbit_group_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a [3];
  logic        stop_a  [3];
  logic [15:0] ns_a    [3];

  logic [2:0]  g0, g1, g2;
  logic        u0, u1, u2, b0, b1, b2, s0, s1, s2, d0, d1, d2;
  logic [15:0] c0, c1;
  logic [1:0]  c2;

  logic [2:0]  grp_a  [3];
  logic        upd_a  [3];
  logic        busy_a [3];
  logic        sd_a   [3];
  logic        done_a [3];
  logic [15:0] cnt_a  [3];

  always_comb begin
    grp_a[0] = g0; grp_a[1] = g1; grp_a[2] = g2;
    upd_a[0] = u0; upd_a[1] = u1; upd_a[2] = u2;
    busy_a[0] = b0; busy_a[1] = b1; busy_a[2] = b2;
    sd_a[0] = s0; sd_a[1] = s1; sd_a[2] = s2;
    done_a[0] = d0; done_a[1] = d1; done_a[2] = d2;
    cnt_a[0] = c0; cnt_a[1] = c1; cnt_a[2] = {14'd0, c2};
  end

  pbit_group_scheduler #(.NUM_GROUPS(4), .SETTLE_CYCLES(3), .SWEEP_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .stop(stop_a[0]), .num_sweeps(ns_a[0]),
    .group_EN(g0), .update_en(u0), .busy(b0), .sweep_done(s0), .done(d0), .sweep_count(c0)
  );

  pbit_group_scheduler #(.NUM_GROUPS(4), .SETTLE_CYCLES(1), .SWEEP_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .stop(stop_a[1]), .num_sweeps(ns_a[1]),
    .group_EN(g1), .update_en(u1), .busy(b1), .sweep_done(s1), .done(d1), .sweep_count(c1)
  );

  pbit_group_scheduler #(.NUM_GROUPS(4), .SETTLE_CYCLES(3), .SWEEP_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .stop(stop_a[2]), .num_sweeps(ns_a[2][1:0]),
    .group_EN(g2), .update_en(u2), .busy(b2), .sweep_done(s2), .done(d2), .sweep_count(c2)
  );

  int checks = 0;
  int errors = 0;
  int settle_of [3] = '{3, 1, 3};
  int maxc_of   [3] = '{65535, 65535, 3};

  typedef struct {
    int idx;
    int target;
    int stop_cyc;
    bit noise;
    int exp_sweeps;
    int exp_count;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input int i, input string tag);
    chk({tag, "_group"}, 32'(grp_a[i]), 0);
    chk({tag, "_update_en"}, 32'(upd_a[i]), 0);
    chk({tag, "_busy"}, 32'(busy_a[i]), 0);
    chk({tag, "_sweep_done"}, 32'(sd_a[i]), 0);
    chk({tag, "_done"}, 32'(done_a[i]), 0);
  endtask

  // Start at the edge closing cycle 0; cycle c is the period after edge c-1.
  task automatic run(input int idx, input int target, input int stop_cyc, input bit noise,
                     input int exp_sweeps, input int exp_count);
    int s, len, n, ns_stop, sd_seen, cexp, gexp;
    bit b;
    s = settle_of[idx];
    len = N * s;
    n = target;
    if (stop_cyc > 0) begin
      ns_stop = (stop_cyc - 1) / len + 1;
      if (target == 0 || ns_stop < target) n = ns_stop;
    end
    sd_seen = 0;
    if (noise) begin
      @(negedge clk);
      stop_a[idx] = 1'b1;
      @(negedge clk);
      stop_a[idx] = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy_a[idx]), 0);
    chk("idle_done", 32'(done_a[idx]), 0);
    start_a[idx] = 1'b1;
    ns_a[idx] = 16'(target);
    for (int c = 1; c <= len * n + 2; c++) begin
      @(negedge clk);
      b = (c <= len * n);
      gexp = b ? ((c - 1) / s) % N : 0;
      cexp = (c - 1) / len;
      if (cexp > n) cexp = n;
      if (cexp > maxc_of[idx]) cexp = maxc_of[idx];
      chk("group_EN", 32'(grp_a[idx]), 32'(gexp));
      chk("update_en", 32'(upd_a[idx]), 32'(b && ((c - 1) % s == 0)));
      chk("busy", 32'(busy_a[idx]), 32'(b));
      chk("sweep_done", 32'(sd_a[idx]), 32'(b && (c % len == 0)));
      chk("done", 32'(done_a[idx]), 32'(c == len * n + 1));
      chk("sweep_count", 32'(cnt_a[idx]), 32'(cexp));
      if (sd_a[idx]) sd_seen++;
      start_a[idx] = (noise && c <= len * n) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise && c <= len * n) ns_a[idx] = 16'($urandom_range(0, 7));
      stop_a[idx] = (c == stop_cyc) || (noise && c == len * n + 1);
    end
    start_a[idx] = 1'b0;
    stop_a[idx] = 1'b0;
    ns_a[idx] = '0;
    chk("sweeps_seen", 32'(sd_seen), 32'(exp_sweeps));
    chk("final_count", 32'(cnt_a[idx]), 32'(exp_count));
  endtask

  vec_t vecs [9];

  initial begin
    int t, p, n, ns_stop;
    vecs[0] = '{0, 2, 0,  1'b0, 2, 2};  // bounded run
    vecs[1] = '{0, 0, 5,  1'b0, 1, 1};  // free run plus stop
    vecs[2] = '{0, 2, 0,  1'b1, 2, 2};  // ignored start / num_sweeps / stop
    vecs[3] = '{0, 1, 0,  1'b1, 1, 1};  // stop in idle first
    vecs[4] = '{1, 3, 0,  1'b0, 3, 3};  // single-cycle settle
    vecs[5] = '{2, 0, 54, 1'b0, 5, 3};  // count saturation
    vecs[6] = '{0, 0, 12, 1'b0, 1, 1};  // stop in final cycle of sweep
    vecs[7] = '{0, 3, 13, 1'b0, 2, 2};  // stop early in second sweep
    vecs[8] = '{2, 3, 0,  1'b0, 3, 3};  // target equals saturated value

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      stop_a[i] = 1'b0;
      ns_a[i] = '0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_quiet(i, "reset");
      chk("reset_count", 32'(cnt_a[i]), 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k])
      run(vecs[k].idx, vecs[k].target, vecs[k].stop_cyc, vecs[k].noise,
          vecs[k].exp_sweeps, vecs[k].exp_count);

    // Asynchronous reset in the middle of group 2.
    @(negedge clk);
    start_a[0] = 1'b1;
    ns_a[0] = 16'd2;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_a[0] = 1'b0;
    end
    chk("pre_reset_group", 32'(grp_a[0]), 2);
    chk("pre_reset_busy", 32'(busy_a[0]), 1);
    rst_n = 1'b0;
    #1;
    chk_quiet(0, "midrun_reset");
    chk("midrun_reset_count", 32'(cnt_a[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_reset_done", 32'(done_a[0]), 0);
      chk("post_reset_busy", 32'(busy_a[0]), 0);
    end
    run(0, 1, 0, 1'b0, 1, 1);

    // Randomised runs checked by the schedule model.
    for (int r = 0; r < 10; r++) begin
      t = $urandom_range(0, 3);
      if (t == 0) p = $urandom_range(1, 36);
      else p = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12 * t) : 0;
      n = t;
      if (p > 0) begin
        ns_stop = (p - 1) / 12 + 1;
        if (t == 0 || ns_stop < t) n = ns_stop;
      end
      run(0, t, p, 1'($urandom_range(0, 1)), n, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pbit_group_scheduler.md
# pbit_group_scheduler

Sequences the grouped (graph-coloured) update of the p-bit network in the 4-bit integer-factorization design. It steps a group index through `0 … NUM_GROUPS-1`, holding each group for a fixed settle window. That index drives the group-to-p-bit-enable lookup, so only one colour class of p-bits updates at a time. It also counts full sweeps, runs either a programmed number of sweeps or until told to stop, and pulses at every sweep boundary so the readout logic can sample a consistent state.

## Interface
Parameters:
- `NUM_GROUPS`, 4: number of colour groups per sweep; legal range 1..8.
- `SETTLE_CYCLES`, 3: clock cycles each group stays selected; ≥1.
- `SWEEP_W`, 16: width of the sweep target and sweep counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: run request; sampled only in IDLE.
- `stop` in 1: graceful stop request; sampled only while running.
- `num_sweeps` in SWEEP_W: sweep target, sampled on accepted start; 0 means run until stopped.
- `group_EN` out 3: current group index; feeds the group-enable lookup.
- `update_en` out 1: one-cycle strobe in the first cycle of each group slot.
- `busy` out 1: high while in RUN.
- `sweep_done` out 1: one-cycle pulse in the last cycle of each complete sweep.
- `done` out 1: one-cycle pulse after the final sweep.
- `sweep_count` out SWEEP_W: number of completed sweeps since the last accepted start.

## Operation
States and transitions:
- IDLE → RUN on `start`.
- RUN → DONE at the end of the last slot of a sweep, when the target is reached or a stop is pending.
- RUN → RUN (back to slot 0) otherwise.
- DONE → IDLE unconditionally, after 1 cycle.

Accepted start:
- Latches `num_sweeps` into an internal target.
- Clears `sweep_count` and any pending stop.
- Clears the slot counter and the group index.

Slot sequencing in RUN:
- Slot counter counts 0..SETTLE_CYCLES-1.
- At wrap, `group_EN` increments. After `NUM_GROUPS-1` it returns to 0 and the sweep completes.

End of sweep (last cycle of the last group's slot):
- `sweep_done`=1 for that cycle.
- `sweep_count` increments at the closing edge; it saturates at all-ones.
- The run ends if the target is nonzero and the new count equals the target, or if stop is pending.

Stop handling:
- `stop` while in RUN sets a sticky pending flag. The current sweep always completes; there is never a partial sweep.
- `stop` in IDLE or DONE is ignored.
- `stop` asserted in the final cycle of a sweep counts as pending for that same sweep boundary.

Other inputs:
- `start` while in RUN or DONE is ignored.
- `num_sweeps` changes after acceptance have no effect.

Outputs outside RUN:
- `group_EN`=0, `update_en`=0, `busy`=0, `sweep_done`=0.
- `sweep_count` holds its last value until the next accepted start.
- `done` is high only in DONE.

Reset:
- `rst_n` low forces IDLE immediately, even mid-run, and clears the stop flag, slot counter and target.
- Every output is 0 during and after reset, including `sweep_count`.
- No `done` pulse is generated by a reset.

## Timing
- Start latency: `start` high at edge k → cycle k+1 has `busy`=1, `group_EN`=0, `update_en`=1.
- Slot timing: each group is held exactly SETTLE_CYCLES cycles; `update_en` is high only in the first of them.
- With SETTLE_CYCLES=1, `update_en` stays high every RUN cycle.
- Sweep length: NUM_GROUPS×SETTLE_CYCLES cycles.
- Slot position: for a sweep starting at cycle s, group g's slot begins at cycle s+g×SETTLE_CYCLES.
- `sweep_count` updates in the cycle after `sweep_done`.
- Final sweep: on the cycle after the last `sweep_done`, `busy`=0 and `done`=1. IDLE follows one cycle later, so `start` is accepted at the earliest 2 cycles after the last `sweep_done`.
- All outputs are registered. `group_EN` and `update_en` change only on clock edges, so the downstream lookup output is valid for the entire slot.

## Test plan
Defaults: NUM_GROUPS=4, SETTLE_CYCLES=3. Start pulsed at edge 0.
- **Bounded run:** `num_sweeps`=2 → `busy` high cycles 1–24; `update_en` at 1,4,7,…,22; `group_EN` sequence 0,1,2,3 repeated twice; `sweep_done` at 12 and 24; `done` at 25; `sweep_count`=2.
- **Free run plus stop:** `num_sweeps`=0, `stop` pulsed at cycle 5 → sweep completes; `sweep_done` at 12; `done` at 13; `sweep_count`=1; no slot of a second sweep appears.
- **Reset mid-run:** `rst_n` driven low at cycle 8 (group 2) → all outputs 0 that same cycle with no clock edge required; no `done` pulse; a fresh start afterwards begins at group 0 with count 0.
- **Ignored inputs:** `start` re-pulsed at cycle 6 and `num_sweeps` changed to 5 mid-run → timing identical to the bounded-run case; `stop` pulsed in IDLE, then start with `num_sweeps`=1 → runs the full sweep.
- **SETTLE_CYCLES=1, NUM_GROUPS=4, `num_sweeps`=3:** `update_en` continuous cycles 1–12; `group_EN` 0,1,2,3 repeating; `sweep_done` at 4, 8, 12; `done` at 13.
- **Saturation:** SWEEP_W=2, `num_sweeps`=0, run 5 sweeps then stop → `sweep_count` reads 3 and never wraps to 0.
